// File: rtl/multdiv.sv
// multdiv: iterative signed multiplier / divider for the execute stage.
//   Multiply: radix-2 Booth, one step per cycle over a 2*WIDTH+1 product register.
//   Divide:   restoring division on operand magnitudes, one quotient bit per cycle,
//             with the sign fixed up at the end.
// Ports:
//   clock           rising-edge clock
//   reset           asynchronous active-low reset
//   data_operandA   multiplicand / dividend (two's complement)
//   data_operandB   multiplier / divisor (two's complement)
//   ctrl_MULT       start-multiply pulse (wins over ctrl_DIV)
//   ctrl_DIV        start-divide pulse
//   data_result     low WIDTH bits of product, or quotient truncated toward zero
//   data_exception  multiply overflow, divide-by-zero or divide overflow
//   data_resultRDY  one-cycle strobe: result/exception valid
//   busy            operation in flight (pipeline stall request)
module multdiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ZERO_W  = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES_W  = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MIN_W   = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_IT = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] ONE_C   = {{(CNT_W-1){1'b0}}, 1'b1};

  // Two's complement negate; magnitude of MIN_W stays MIN_W, which is
  // exactly 2^(WIDTH-1) when read as unsigned.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + ONE_W;
  endfunction

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? negate(v) : v;
  endfunction

  state_t             state, state_next;
  logic [CNT_W-1:0]   counter;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH:0]   prod;
  logic [WIDTH-1:0]   rem;
  logic [WIDTH-1:0]   quo;
  logic [WIDTH-1:0]   dvsr;
  logic               op_div;
  logic               q_neg;
  logic               div_zero;
  logic               div_ovf;

  logic               start;
  logic               start_div;
  logic [WIDTH:0]     booth_sum;
  logic [2*WIDTH:0]   prod_step;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH:0]     div_diff;
  logic [WIDTH-1:0]   rem_step;
  logic [WIDTH-1:0]   quo_step;
  logic [WIDTH-1:0]   result_next;
  logic               exc_next;
  logic               rdy_next;
  logic               busy_next;
  logic [WIDTH:0]     prod_top;

  assign start     = ctrl_MULT | ctrl_DIV;
  assign start_div = ctrl_DIV & ~ctrl_MULT;

  // Booth step: add/subtract in WIDTH+1 bits so that subtracting MIN_W keeps
  // its true sign, then arithmetic shift right across the whole register.
  always_comb begin
    booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    case (prod[1:0])
      2'b01:   booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]} + {mcand[WIDTH-1], mcand};
      2'b10:   booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]} - {mcand[WIDTH-1], mcand};
      default: booth_sum = {prod[2*WIDTH], prod[2*WIDTH:WIDTH+1]};
    endcase
    prod_step = {booth_sum, prod[WIDTH:1]};
  end

  // Restoring divide step: shift in the next dividend bit, keep the
  // difference only when it did not go negative.
  always_comb begin
    div_shift = {rem, quo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, dvsr};
    if (div_diff[WIDTH]) begin
      rem_step = div_shift[WIDTH-1:0];
    end else begin
      rem_step = div_diff[WIDTH-1:0];
    end
    quo_step = {quo[WIDTH-2:0], ~div_diff[WIDTH]};
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a start pulse restarts from any state. The DONE cycle
  // is where the final value is formed; the strobe is registered out of it.
  always_comb begin
    state_next = state;
    if (start) begin
      state_next = ctrl_MULT ? S_MUL : S_DIV;
    end else begin
      case (state)
        S_IDLE:  state_next = S_IDLE;
        S_MUL:   state_next = (counter == LAST_IT) ? S_DONE : S_MUL;
        S_DIV:   state_next = (div_zero || (counter == LAST_IT)) ? S_DONE : S_DIV;
        S_DONE:  state_next = S_IDLE;
        default: state_next = S_IDLE;
      endcase
    end
  end

  // Datapath: operand capture on start, one iteration per cycle otherwise.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      counter  <= '0;
      mcand    <= '0;
      prod     <= '0;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      op_div   <= 1'b0;
      q_neg    <= 1'b0;
      div_zero <= 1'b0;
      div_ovf  <= 1'b0;
    end else if (start) begin
      counter  <= '0;
      mcand    <= data_operandA;
      prod     <= {ZERO_W, data_operandB, 1'b0};
      rem      <= ZERO_W;
      quo      <= magnitude(data_operandA);
      dvsr     <= magnitude(data_operandB);
      op_div   <= start_div;
      q_neg    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      div_zero <= (data_operandB == ZERO_W);
      div_ovf  <= (data_operandA == MIN_W) && (data_operandB == ONES_W);
    end else if (state == S_MUL) begin
      prod    <= prod_step;
      counter <= counter + ONE_C;
    end else if ((state == S_DIV) && !div_zero) begin
      rem     <= rem_step;
      quo     <= quo_step;
      counter <= counter + ONE_C;
    end else begin
      counter <= counter;
    end
  end

  assign prod_top = prod[2*WIDTH:WIDTH];

  // Output logic: final result in DONE, otherwise hold the last completion.
  always_comb begin
    result_next = data_result;
    exc_next    = data_exception;
    rdy_next    = 1'b0;
    busy_next   = start | (state == S_MUL) | (state == S_DIV);
    if (state == S_DONE) begin
      rdy_next = 1'b1;
      if (!op_div) begin
        result_next = prod[WIDTH:1];
        exc_next    = !((prod_top == {(WIDTH+1){1'b0}}) || (prod_top == {(WIDTH+1){1'b1}}));
      end else if (div_zero) begin
        result_next = ZERO_W;
        exc_next    = 1'b1;
      end else begin
        result_next = q_neg ? negate(quo) : quo;
        exc_next    = div_ovf;
      end
    end else begin
      rdy_next = 1'b0;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_result    <= '0;
      data_exception <= 1'b0;
      data_resultRDY <= 1'b0;
      busy           <= 1'b0;
    end else begin
      data_result    <= result_next;
      data_exception <= exc_next;
      data_resultRDY <= rdy_next;
      busy           <= busy_next;
    end
  end

endmodule

// File: tb/tb_multdiv.sv
// tb_multdiv: directed self-checking bench for multdiv.
module tb_multdiv;

  logic        clock;
  logic        reset;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_result;
  logic        data_exception;
  logic        data_resultRDY;
  logic        busy;

  int vectors;
  int miscompares;

  multdiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Drive a start pulse so that it is sampled on the next rising edge (E0);
  // returns 1 ns after E0.
  task automatic launch(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    data_operandA = a;
    data_operandB = b;
    ctrl_MULT     = m;
    ctrl_DIV      = d;
    @(posedge clock);
    #1;
    ctrl_MULT = 1'b0;
    ctrl_DIV  = 1'b0;
  endtask

  // Wait up to 40 edges for the ready strobe; lat = edges after E0, -1 on timeout.
  task automatic wait_rdy(output int lat, output logic [31:0] res, output logic exc);
    lat = -1;
    res = 32'h0;
    exc = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) begin
        lat = k;
        res = data_result;
        exc = data_exception;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    reset = 1'b0;
    #10;
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0) begin
      miscompares++;
      $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b, want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_mul();
    logic [31:0] ta [3] = '{32'd7, 32'h0001_0000, 32'h8000_0000};
    logic [31:0] tb [3] = '{32'hFFFF_FFFD, 32'h0001_0000, 32'd1};
    logic [31:0] tr [3] = '{32'hFFFF_FFEB, 32'h0000_0000, 32'h8000_0000};
    logic        te [3] = '{1'b0, 1'b1, 1'b0};
    int lat;
    logic [31:0] res;
    logic exc;
    for (int i = 0; i < 3; i++) begin
      launch(1'b1, 1'b0, ta[i], tb[i]);
      vectors++;
      if (busy !== 1'b1) begin
        miscompares++;
        $display("FAIL mul_busy[%0d]: got %b want 1", i, busy);
      end
      wait_rdy(lat, res, exc);
      vectors++;
      if (lat !== 33) begin
        miscompares++;
        $display("FAIL mul_latency[%0d]: got %0d want 33", i, lat);
      end
      vectors++;
      if (res !== tr[i] || exc !== te[i]) begin
        miscompares++;
        $display("FAIL mul_result[%0d]: got %h/%b want %h/%b", i, res, exc, tr[i], te[i]);
      end
      @(posedge clock);
      #1;
      vectors++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== tr[i]) begin
        miscompares++;
        $display("FAIL mul_after[%0d]: got rdy=%b busy=%b res=%h want 0 0 %h",
                 i, data_resultRDY, busy, data_result, tr[i]);
      end
    end
  endtask

  task automatic test_div();
    logic [31:0] ta [4] = '{32'hFFFF_FFF9, 32'd100, 32'd5, 32'h8000_0000};
    logic [31:0] tb [4] = '{32'd2, 32'd7, 32'd0, 32'hFFFF_FFFF};
    logic [31:0] tr [4] = '{32'hFFFF_FFFD, 32'd14, 32'd0, 32'h8000_0000};
    logic        te [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    int          tl [4] = '{33, 33, 2, 33};
    int lat;
    logic [31:0] res;
    logic exc;
    for (int i = 0; i < 4; i++) begin
      launch(1'b0, 1'b1, ta[i], tb[i]);
      wait_rdy(lat, res, exc);
      vectors++;
      if (lat !== tl[i]) begin
        miscompares++;
        $display("FAIL div_latency[%0d]: got %0d want %0d", i, lat, tl[i]);
      end
      vectors++;
      if (res !== tr[i] || exc !== te[i]) begin
        miscompares++;
        $display("FAIL div_result[%0d]: got %h/%b want %h/%b", i, res, exc, tr[i], te[i]);
      end
      @(posedge clock);
      #1;
      vectors++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL div_after[%0d]: got rdy=%b busy=%b want 0 0", i, data_resultRDY, busy);
      end
    end
  endtask

  task automatic test_abort();
    int lat;
    logic [31:0] res;
    logic exc;
    int early;
    early = 0;
    launch(1'b1, 1'b0, 32'd3, 32'd4);
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) early++;
    end
    launch(1'b0, 1'b1, 32'd20, 32'd5);
    wait_rdy(lat, res, exc);
    vectors++;
    if (early != 0 || lat !== 33) begin
      miscompares++;
      $display("FAIL abort_latency: got early=%0d lat=%0d want 0 and 33", early, lat);
    end
    vectors++;
    if (res !== 32'd4 || exc !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_result: got %h/%b want 00000004/0", res, exc);
    end
    // Both start pulses together: multiply must win.
    launch(1'b1, 1'b1, 32'd6, 32'd7);
    wait_rdy(lat, res, exc);
    vectors++;
    if (lat !== 33 || res !== 32'd42 || exc !== 1'b0) begin
      miscompares++;
      $display("FAIL both_ctrl: got lat=%0d res=%h exc=%b want 33 0000002a 0", lat, res, exc);
    end
  endtask

  task automatic test_back_to_back();
    int lat;
    logic [31:0] res;
    logic exc;
    launch(1'b1, 1'b0, 32'd2, 32'd3);
    repeat (32) @(posedge clock);
    // Second start sampled on the first op's ready edge.
    launch(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
    vectors++;
    if (data_resultRDY !== 1'b1 || data_result !== 32'd6 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_first: got rdy=%b res=%h busy=%b want 1 00000006 1",
               data_resultRDY, data_result, busy);
    end
    wait_rdy(lat, res, exc);
    vectors++;
    if (lat !== 33 || res !== 32'hFFFF_FFF2 || exc !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_second: got lat=%0d res=%h exc=%b want 33 fffffff2 0", lat, res, exc);
    end
  endtask

  task automatic test_async_reset();
    int lat;
    logic [31:0] res;
    logic exc;
    int strobes;
    strobes = 0;
    launch(1'b1, 1'b0, 32'd5, 32'd5);
    repeat (14) @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    vectors++;
    if ({data_result, data_exception, data_resultRDY, busy} !== 35'h0) begin
      miscompares++;
      $display("FAIL async_reset: got res=%h exc=%b rdy=%b busy=%b want all 0",
               data_result, data_exception, data_resultRDY, busy);
    end
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    repeat (25) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) strobes++;
    end
    vectors++;
    if (strobes != 0) begin
      miscompares++;
      $display("FAIL reset_no_rdy: got %0d active cycles want 0", strobes);
    end
    launch(1'b1, 1'b0, 32'd6, 32'd6);
    wait_rdy(lat, res, exc);
    vectors++;
    if (lat !== 33 || res !== 32'd36 || exc !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset_mul: got lat=%0d res=%h exc=%b want 33 00000024 0", lat, res, exc);
    end
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    data_operandA = 32'h0;
    data_operandB = 32'h0;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_abort();
    test_back_to_back();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
